char_audio_player: RTL and testbench

//  Playback responder for the keystroke controller. On a start request, maps the latched ASCII digit to a

---
 rtl/char_audio_player.sv | 205 ++++++++++++++++++++
 tb/tb_char_audio_player.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/char_audio_player.sv
// char_audio_player: plays the flash audio segment selected by an ASCII digit.
// Each 32-bit flash word holds two samples, bytes [15:8] then [31:24].
// Optional feature: define CHAR_AUDIO_ERRTONE_EN so that an invalid character
// plays segment 10 (the error tone) instead of finishing with no audio.
//
//  state   | meaning
//  IDLE    | waiting for an armed start request
//  LOOKUP  | latched char decoded into segment start / last address
//  REQ     | flash_read held with a stable address until waitrequest is low
//  WAIT_D  | read accepted, waiting for readdatavalid
//  PLAY_LO | word held, next sample_tick emits byte [15:8]
//  PLAY_HI | next sample_tick emits byte [31:24], then next word or finish
//  DONE    | one-cycle done pulse, held back one cycle behind a final sample
module char_audio_player #(
  parameter int unsigned       SEG_WORDS = 32'd4096,
  parameter int unsigned       ADDR_W    = 23,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              read_addr_start,
  input  logic [7:0]        valid_char,
  input  logic              sample_tick,
  output logic              flash_read,
  output logic [ADDR_W-1:0] flash_address,
  input  logic              flash_waitrequest,
  input  logic [31:0]       flash_readdata,
  input  logic              flash_readdatavalid,
  output logic [7:0]        sample_out,
  output logic              sample_valid,
  output logic              audio_done_flag,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_REQ,
    S_WAIT_D,
    S_PLAY_LO,
    S_PLAY_HI,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] SEG_SPAN = ADDR_W'(SEG_WORDS);
  localparam logic [ADDR_W-1:0] LAST_OFS = ADDR_W'(SEG_WORDS - 32'd1);

  state_t            state;
  state_t            state_nxt;
  logic              armed;
  logic [7:0]        char_q;
  logic [ADDR_W-1:0] last_addr;
  logic [7:0]        byte_lo;
  logic [7:0]        byte_hi;

  logic              char_ok;
  logic              seg_go;
  logic [3:0]        seg_idx;
  logic [ADDR_W-1:0] seg_start;

  logic              accept;
  logic              load_seg;
  logic              latch_word;
  logic              emit_lo;
  logic              emit_hi;
  logic              next_word;

  // Only the two sample bytes of each flash word are ever played.
  logic              unused_rd;
  assign unused_rd = ^{flash_readdata[23:16], flash_readdata[7:0]};

  // Segment decode: for '0'..'9' the low nibble of the ASCII code is the index.
  always_comb begin
    char_ok = (char_q >= 8'h30) && (char_q <= 8'h39);
`ifdef CHAR_AUDIO_ERRTONE_EN
    seg_idx = char_ok ? char_q[3:0] : 4'd10;
    seg_go  = 1'b1;
`else
    seg_idx = char_q[3:0];
    seg_go  = char_ok;
`endif
    seg_start = BASE_ADDR + ADDR_W'(seg_idx) * SEG_SPAN;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic, control strobes and state-decoded outputs.
  always_comb begin
    state_nxt       = state;
    flash_read      = 1'b0;
    busy            = 1'b1;
    audio_done_flag = 1'b0;
    accept          = 1'b0;
    load_seg        = 1'b0;
    latch_word      = 1'b0;
    emit_lo         = 1'b0;
    emit_hi         = 1'b0;
    next_word       = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (read_addr_start && armed) begin
          accept    = 1'b1;
          state_nxt = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (seg_go) begin
          load_seg  = 1'b1;
          state_nxt = S_REQ;
        end else begin
          state_nxt = S_DONE;
        end
      end
      S_REQ: begin
        flash_read = 1'b1;
        if (!flash_waitrequest) begin
          state_nxt = S_WAIT_D;
        end
      end
      S_WAIT_D: begin
        if (flash_readdatavalid) begin
          latch_word = 1'b1;
          state_nxt  = S_PLAY_LO;
        end
      end
      S_PLAY_LO: begin
        if (sample_tick) begin
          emit_lo   = 1'b1;
          state_nxt = S_PLAY_HI;
        end
      end
      S_PLAY_HI: begin
        if (sample_tick) begin
          emit_hi = 1'b1;
          if (flash_address == last_addr) begin
            state_nxt = S_DONE;
          end else begin
            next_word = 1'b1;
            state_nxt = S_REQ;
          end
        end
      end
      S_DONE: begin
        // Arriving from PLAY_HI the final sample_valid is showing this cycle;
        // wait one cycle so the done pulse trails it. From LOOKUP no sample
        // is pending and the pulse goes out immediately.
        if (!sample_valid) begin
          audio_done_flag = 1'b1;
          state_nxt       = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: arming, char latch, address walk, word latch and sample output.
  always_ff @(posedge clk) begin
    if (reset) begin
      armed         <= 1'b1;
      char_q        <= 8'h00;
      flash_address <= BASE_ADDR;
      last_addr     <= BASE_ADDR;
      byte_lo       <= 8'h00;
      byte_hi       <= 8'h00;
      sample_out    <= 8'h00;
      sample_valid  <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (!read_addr_start) begin
        armed <= 1'b1;
      end else if (accept) begin
        armed <= 1'b0;
      end
      if (accept) begin
        char_q <= valid_char;
      end
      if (load_seg) begin
        flash_address <= seg_start;
        last_addr     <= seg_start + LAST_OFS;
      end else if (next_word) begin
        flash_address <= flash_address + ADDR_W'(1);
      end
      if (latch_word) begin
        byte_lo <= flash_readdata[15:8];
        byte_hi <= flash_readdata[31:24];
      end
      if (emit_lo) begin
        sample_out   <= byte_lo;
        sample_valid <= 1'b1;
      end else if (emit_hi) begin
        sample_out   <= byte_hi;
        sample_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_char_audio_player.sv
// Bench for char_audio_player: flash responder with configurable stall,
// scoreboard of expected read addresses and samples.
module tb_char_audio_player;

  localparam int SEG  = 4;
  localparam int BASE = 'h100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        read_addr_start = 1'b0;
  logic [7:0]  valid_char = 8'h00;
  logic        sample_tick = 1'b0;
  logic        flash_read;
  logic [22:0] flash_address;
  logic        flash_waitrequest = 1'b0;
  logic [31:0] flash_readdata = 32'h0;
  logic        flash_readdatavalid = 1'b0;
  logic [7:0]  sample_out;
  logic        sample_valid;
  logic        audio_done_flag;
  logic        busy;

  char_audio_player #(
    .SEG_WORDS(SEG),
    .ADDR_W   (23),
    .BASE_ADDR(23'(BASE))
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .read_addr_start    (read_addr_start),
    .valid_char         (valid_char),
    .sample_tick        (sample_tick),
    .flash_read         (flash_read),
    .flash_address      (flash_address),
    .flash_waitrequest  (flash_waitrequest),
    .flash_readdata     (flash_readdata),
    .flash_readdatavalid(flash_readdatavalid),
    .sample_out         (sample_out),
    .sample_valid       (sample_valid),
    .audio_done_flag    (audio_done_flag),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [22:0] addr_q[$];
  logic [7:0]  sample_q[$];

  int cyc = 0;
  int sv_cnt = 0;
  int last_sv_cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int reads = 0;
  int stall_cfg = 0;
  int tcnt = 0;
  bit stray_req = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] data_of(input logic [22:0] a);
    logic [7:0] b;
    b = a[7:0];
    return {b ^ 8'hA5, ~b, b ^ 8'h5A, b};
  endfunction

  // Sample tick: one-cycle pulse every 4 clocks.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      tcnt++;
      sample_tick = (tcnt % 4 == 0);
    end
  end

  // Output monitor and flash responder, evaluated on the falling edge.
  initial begin
    int          stall_left;
    int          resp_delay;
    int          outstanding;
    bit          in_req;
    logic [22:0] req_addr;
    logic [31:0] resp_data;
    logic [22:0] e_addr;
    stall_left = 0;
    resp_delay = 0;
    outstanding = 0;
    in_req = 0;
    req_addr = '0;
    resp_data = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        flash_readdatavalid = 1'b0;
        flash_waitrequest = 1'b0;
        resp_delay = 0;
        outstanding = 0;
        in_req = 0;
      end else begin
        if (sample_valid) begin
          sv_cnt++;
          last_sv_cyc = cyc;
          if (sample_q.size() == 0) chk("sample_extra", 1, 0);
          else chk("sample", sample_out, sample_q.pop_front());
        end
        if (audio_done_flag) begin
          done_cnt++;
          done_cyc = cyc;
        end
        flash_readdatavalid = 1'b0;
        if (resp_delay > 0) begin
          resp_delay--;
          if (resp_delay == 0) begin
            flash_readdatavalid = 1'b1;
            flash_readdata = resp_data;
            sample_q.push_back(resp_data[15:8]);
            sample_q.push_back(resp_data[31:24]);
            outstanding--;
          end
        end else if (stray_req && !flash_read) begin
          flash_readdatavalid = 1'b1;
          flash_readdata = 32'hDEAD_BEEF;
          stray_req = 0;
        end
        if (flash_read) begin
          if (!in_req) begin
            in_req = 1;
            req_addr = flash_address;
            stall_left = stall_cfg;
          end else begin
            chk("addr_stable", flash_address, req_addr);
          end
          if (stall_left > 0) begin
            flash_waitrequest = 1'b1;
            stall_left--;
          end else begin
            flash_waitrequest = 1'b0;
            in_req = 0;
            reads++;
            if (addr_q.size() == 0) begin
              chk("read_extra", flash_address, 0);
            end else begin
              e_addr = addr_q.pop_front();
              chk("read_addr", flash_address, e_addr);
            end
            chk("outstanding", outstanding, 0);
            outstanding++;
            resp_data = data_of(flash_address);
            resp_delay = 2;
          end
        end else begin
          flash_waitrequest = 1'b0;
        end
      end
    end
  end

  task automatic push_segment(input logic [7:0] ch, output bit go);
    int idx;
    go = 1;
    idx = 0;
    if (ch >= 8'h30 && ch <= 8'h39) begin
      idx = int'(ch) - 'h30;
    end else begin
`ifdef CHAR_AUDIO_ERRTONE_EN
      idx = 10;
`else
      go = 0;
`endif
    end
    if (go) begin
      for (int w = 0; w < SEG; w++) addr_q.push_back(23'(BASE + idx * SEG + w));
    end
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  // One playback: raise start, check timing, wait for done.
  // hold=0 drops start mid-playback (must be ignored); hold=1 keeps it high.
  task automatic run_char(input logic [7:0] ch, input int stall, input bit hold);
    bit go;
    int d0, r0, s0, acc;
    push_segment(ch, go);
    stall_cfg = stall;
    d0 = done_cnt;
    r0 = reads;
    s0 = sv_cnt;
    @(posedge clk);
    #1;
    valid_char = ch;
    read_addr_start = 1'b1;
    acc = cyc + 1;
    @(negedge clk);
    #1;
    chk("busy_idle", busy, 0);
    @(negedge clk);
    #1;
    chk("busy_run", busy, 1);
    valid_char = 8'h2A;
    if (!hold) read_addr_start = 1'b0;
    for (int i = 0; i < 400 && done_cnt == d0; i++) begin
      @(negedge clk);
      #1;
    end
    chk("done_cnt", done_cnt, d0 + 1);
    if (go) begin
      chk("n_samples", sv_cnt - s0, 2 * SEG);
      chk("n_reads", reads - r0, SEG);
      chk("done_lat", done_cyc, last_sv_cyc + 1);
    end else begin
      chk("n_samples_inv", sv_cnt - s0, 0);
      chk("n_reads_inv", reads - r0, 0);
      chk("done_lat_inv", done_cyc, acc + 2);
    end
    chk("addr_left", addr_q.size(), 0);
    @(negedge clk);
    #1;
    chk("done_once", audio_done_flag, 0);
    chk("busy_after", busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d0, r0, s0;
    bit go;
    wait_cycles(3);
    chk("rst_flash_read", flash_read, 0);
    chk("rst_flash_address", flash_address, BASE);
    chk("rst_sample_out", sample_out, 0);
    chk("rst_sample_valid", sample_valid, 0);
    chk("rst_done", audio_done_flag, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    wait_cycles(2);

    run_char(8'h33, 0, 0);
    run_char(8'h30, 0, 0);
    run_char(8'h37, 5, 0);
    run_char(8'h39, 1, 0);

    s0 = sv_cnt;
    stray_req = 1;
    wait_cycles(6);
    chk("stray_ignored", sv_cnt - s0, 0);
    chk("stray_busy", busy, 0);

    run_char(8'h35, 0, 1);
    d0 = done_cnt;
    r0 = reads;
    wait_cycles(20);
    chk("held_no_done", done_cnt, d0);
    chk("held_no_read", reads - r0, 0);
    chk("held_busy", busy, 0);
    @(posedge clk);
    #1;
    read_addr_start = 1'b0;
    run_char(8'h34, 2, 0);

    run_char(8'h41, 0, 0);
    run_char(8'h2F, 0, 0);
    run_char(8'h3A, 0, 0);

    push_segment(8'h32, go);
    stall_cfg = 0;
    s0 = sv_cnt;
    @(posedge clk);
    #1;
    valid_char = 8'h32;
    read_addr_start = 1'b1;
    for (int i = 0; i < 200 && sv_cnt == s0; i++) begin
      @(negedge clk);
      #1;
    end
    chk("reach_play_hi", sv_cnt - s0, 1);
    reset = 1'b1;
    read_addr_start = 1'b0;
    d0 = done_cnt;
    @(negedge clk);
    #1;
    chk("abort_flash_read", flash_read, 0);
    chk("abort_sample_out", sample_out, 0);
    chk("abort_sample_valid", sample_valid, 0);
    chk("abort_busy", busy, 0);
    addr_q.delete();
    sample_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    wait_cycles(12);
    chk("abort_no_done", done_cnt, d0);
    run_char(8'h31, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
